// File: rtl/actor_2_window_mean_pkg.sv
// actor_2_window_mean_pkg: shared types, widths and sizing helper for the window-mean actor.
package actor_2_window_mean_pkg;
    typedef enum logic {ACCUM, EMIT} state_t;
    localparam int WINDOW_MAX = 128;
    localparam int DATA_W = 8;
    localparam int COUNT_W = 16;
    function automatic int sum_w(input int window);
        return DATA_W + $clog2(window);
    endfunction
endpackage

// File: rtl/actor_2_window_mean_acc.sv
// actor_2_window_mean_acc: running sum and token count; flags the transfer that completes a window.
module actor_2_window_mean_acc
    import actor_2_window_mean_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        take,
    input  logic [DATA_W-1:0]           data,
    output logic [sum_w(WINDOW)-1:0]    sum_next,
    output logic                        done
);
    localparam int LG = $clog2(WINDOW);
    localparam int SW = sum_w(WINDOW);
    logic [SW-1:0] sum;
    logic [LG:0]   cnt;
    assign sum_next = sum + SW'(data);
    assign done = take && cnt == (LG+1)'(WINDOW - 1);
    always_ff @(posedge CLK) begin
        if (RESET || done) begin
            sum <= '0;
            cnt <= '0;
        end else if (take) begin
            sum <= sum_next;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/actor_2_window_mean.sv
// actor_2_window_mean: averages WINDOW input tokens and offers the mean as one output token.
// Defining ACTOR_2_WINDOW_MEAN_ROUND_EN rounds the mean half up instead of truncating.
module actor_2_window_mean
    import actor_2_window_mean_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DATA_W-1:0]  x_DATA,
    input  logic [COUNT_W-1:0] x_COUNT,
    input  logic               x_SEND,
    output logic               x_ACK,
    output logic [DATA_W-1:0]  result_DATA,
    output logic [COUNT_W-1:0] result_COUNT,
    output logic               result_SEND,
    input  logic               result_ACK
);
    localparam int LG = $clog2(WINDOW);
    localparam int SW = sum_w(WINDOW);
    state_t state, next_state;
    logic [SW-1:0] sum_next;
    logic [DATA_W-1:0] mean;
    logic done;
    logic unused_count;
    assign unused_count = ^x_COUNT;
    actor_2_window_mean_acc #(.WINDOW(WINDOW)) u_acc (
        .CLK(CLK),
        .RESET(RESET),
        .take(x_SEND && x_ACK),
        .data(x_DATA),
        .sum_next(sum_next),
        .done(done)
    );
`ifdef ACTOR_2_WINDOW_MEAN_ROUND_EN
    logic [SW:0] rsum;
    assign rsum = {1'b0, sum_next} + (SW+1)'(WINDOW / 2);
    assign mean = DATA_W'(rsum >> LG);
`else
    assign mean = DATA_W'(sum_next >> LG);
`endif
    always_ff @(posedge CLK) begin
        state <= next_state;
        if (RESET)
            result_DATA <= '0;
        else if (done)
            result_DATA <= mean;
    end
    always_comb begin
        next_state = RESET ? ACCUM
                   : state == ACCUM ? (done ? EMIT : ACCUM)
                   : (result_ACK ? ACCUM : EMIT);
    end
    // x_ACK is gated by RESET so nothing is consumed in a reset cycle
    always_comb begin
        x_ACK = state == ACCUM && x_SEND && !RESET;
        result_SEND = state == EMIT;
        result_COUNT = {{(COUNT_W-1){1'b0}}, result_SEND};
    end
endmodule

// File: doc/actor_2_window_mean.md
ACTOR_2_WINDOW_MEAN -- requirements
Module: actor_2_window_mean

Interface
REQ-001 Parameter WINDOW, default 4, tokens averaged per output; power of two, 2..128.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-004 x_DATA  input  8  unsigned input token value.
REQ-005 x_COUNT  input  16  upstream token count; ignored; token consumed one at a time.
REQ-006 x_SEND  input  1  upstream offers a valid token on x_DATA.
REQ-007 x_ACK  output  1  actor consumes the x_DATA token this cycle.
REQ-008 result_DATA  output  8  mean of the last completed window.
REQ-009 result_COUNT  output  16  tokens offered: 1 while result_SEND high, else 0.
REQ-010 result_SEND  output  1  result token valid.
REQ-011 result_ACK  input  1  downstream consumes result token this cycle.

Function
REQ-012 Two-state FSM: ACCUM (collect inputs) and EMIT (offer result); reset state ACCUM.
REQ-013 In ACCUM, x_ACK SHALL equal x_SEND combinationally; in EMIT, x_ACK SHALL be 0.
REQ-014 Input transfer occurs in a cycle with x_SEND=1 and x_ACK=1; sum += x_DATA, cnt += 1 at that edge.
REQ-015 Sum register width SHALL be 8+log2(WINDOW) bits; no overflow possible (255*WINDOW fits).
REQ-016 cnt width log2(WINDOW)+1; on the transfer making cnt reach WINDOW, FSM SHALL go to EMIT, load result_DATA = (sum incl. current token) >> log2(WINDOW), clear sum and cnt.
REQ-017 Latency: result_SEND SHALL rise the cycle after the WINDOW-th input transfer.
REQ-018 In EMIT, result_SEND=1, result_COUNT=1, result_DATA held stable until result_ACK=1.
REQ-019 Output transfer on result_SEND=1 and result_ACK=1; FSM returns to ACCUM at that edge; result_SEND=0 next cycle.
REQ-020 result_ACK while result_SEND=0 SHALL be ignored.
REQ-021 Gaps in x_SEND SHALL stall accumulation without losing partial sum or count.
REQ-022 No input accepted in the cycle of an output transfer; earliest next input transfer is the following cycle.
REQ-023 result_DATA retains last value after transfer; only result_SEND qualifies it.

Reset
REQ-024 On RESET=1: FSM=ACCUM, sum=0, cnt=0, result_DATA=0, result_SEND=0, result_COUNT=0, x_ACK=0 during the reset cycle.
REQ-025 Reset mid-window SHALL discard partial sum; reset during EMIT SHALL drop the pending result without transfer.
REQ-026 RESET SHALL take priority over any simultaneous input or output transfer.

Configuration
REQ-027 Macro ACTOR_2_WINDOW_MEAN_ROUND_EN: when defined, result_DATA = (sum + WINDOW/2) >> log2(WINDOW) (round half up, computed in sum width + 1, cannot exceed 255); when undefined, truncating shift only.

Structure
REQ-028 Package actor_2_window_mean_pkg SHALL hold: FSM state enum (ACCUM, EMIT), WINDOW_MAX=128, DATA_W=8, COUNT_W=16, function for sum width from WINDOW.
REQ-029 One sub-module actor_2_window_mean_acc: sum register, cnt counter, window-complete flag; FSM and handshakes stay in top.

Verification
REQ-030 WINDOW=4, inputs 10,20,30,40 back-to-back, result_ACK=1 -> result_SEND one cycle, result_DATA=25, one cycle after 40 accepted.
REQ-031 WINDOW=4, inputs 1,2,2,2 -> result_DATA=1 without ROUND_EN, 2 with ROUND_EN.
REQ-032 WINDOW=4, four inputs of 255 -> result_DATA=255 both configurations, no wrap.
REQ-033 result_ACK held 0 for 5 cycles in EMIT with x_SEND=1 -> result_SEND and result_DATA stable, x_ACK=0 throughout; first input accepted the cycle after the ACK cycle.
REQ-034 RESET after 2 of 4 tokens (99,99), then 4,4,4,4 -> result_DATA=4; RESET during EMIT -> result_SEND=0 next cycle, no transfer.
REQ-035 x_SEND toggling 1,0,0,1,... with WINDOW=8, values 8 each -> result_DATA=8 after eighth accepted token; x_ACK only in x_SEND cycles.
